dm_unit: RTL

- Data memory for the five-stage MIPS pipeline. Sits in the M stage.
- Write side is synchronous and supports sw, sh and sb. Read side is combinational and supports lw, lh, lhu, lb and lbu, with sign or zero extension.
- Counterpart of the fetch-side instruction memory: that block only reads, while this block is the memory the pipeline writes to.
- Flags misaligned accesses and suppresses misaligned stores.

---
 rtl/dm_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/dm_unit.sv
// dm_unit: M-stage data memory for the five-stage MIPS pipeline.
// Synchronous byte/half/word stores, combinational sign/zero-extending loads.
// Misaligned word/half accesses are flagged, and a misaligned store leaves memory untouched.
// The whole array clears in one cycle on reset, so it is built from flops rather than block RAM.
module dm_unit #(
    parameter int          DEPTH = 4096,
    parameter int          AW    = 12,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_we,
    input  logic [1:0]  M_st_op,
    input  logic [2:0]  M_ld_op,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_wdata,
    output logic [31:0] M_rdata,
    output logic        M_addr_err
);

    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_B = 2'b10;

    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          st_en;
    logic [31:0]   word;
    logic [15:0]   half;
    logic [7:0]    byte_sel;
    logic          wr_en_d;
    logic [31:0]   wr_data_d;
    logic          unused_off_bits;

    // Offset from the memory base; the upper bits only alias and are dropped.
    assign off             = M_addr - BASE;
    assign idx             = off[AW+1:2];
    assign lane            = off[1:0];
    assign unused_off_bits = ^off[31:AW+2];

    // st_op 11 is a no-store encoding, so it behaves exactly like M_we = 0.
    assign st_en    = M_we && (M_st_op != 2'b11);
    assign word     = mem_q[idx];
    assign half     = lane[1] ? word[31:16] : word[15:0];
    assign byte_sel = word[{lane, 3'b000} +: 8];

    // Alignment check: store rules when storing, load rules otherwise.
    always_comb begin
        M_addr_err = 1'b0;
        if (st_en) begin
            case (M_st_op)
                ST_W:    M_addr_err = (lane != 2'b00);
                ST_H:    M_addr_err = lane[0];
                default: M_addr_err = 1'b0;
            endcase
        end else begin
            case (M_ld_op)
                LD_H, LD_HU: M_addr_err = lane[0];
                LD_B, LD_BU: M_addr_err = 1'b0;
                default:     M_addr_err = (lane != 2'b00);
            endcase
        end
    end

    // Load result from pre-store contents; no write-to-read bypass.
    always_comb begin
        case (M_ld_op)
            LD_H:    M_rdata = {{16{half[15]}}, half};
            LD_HU:   M_rdata = {16'h0000, half};
            LD_B:    M_rdata = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   M_rdata = {24'h000000, byte_sel};
            default: M_rdata = word;
        endcase
    end

    // Merge the store data into the addressed word (read-modify-write of one word).
    always_comb begin
        wr_en_d   = st_en && !M_addr_err;
        wr_data_d = word;
        case (M_st_op)
            ST_W: wr_data_d = M_wdata;
            ST_H: begin
                if (lane[1]) wr_data_d[31:16] = M_wdata[15:0];
                else         wr_data_d[15:0]  = M_wdata[15:0];
            end
            ST_B: wr_data_d[{lane, 3'b000} +: 8] = M_wdata[7:0];
            default: wr_data_d = word;
        endcase
    end

    // One register per word: reset clears all of them and wins over a store.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (reset)
                    mem_q[gi] <= 32'h0000_0000;
                else if (wr_en_d && (idx == AW'(gi)))
                    mem_q[gi] <= wr_data_d;
            end
        end
    endgenerate

endmodule
